// File: rtl/cpu_display_pkg.sv
// ---------------------------------------------------------------------------
// cpu_display_pkg
// Shared constants for the CPU seven-segment display driver.
//   NUM_DIGITS : number of multiplexed digits on the board
//   SEG_BLANK  : segment pattern with every segment dark (active-low)
//   AN_OFF     : anode pattern with every digit disabled (active-low)
//   SEG_TABLE  : hex nibble -> {g,f,e,d,c,b,a}, active-low, indexed by nibble
// ---------------------------------------------------------------------------
package cpu_display_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [7:0] AN_OFF     = 8'hFF;

   // Packed so that SEG_TABLE[n] yields the pattern for nibble n.
   // Listed from F down to 0.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to seven-segment decoder, active-low outputs.
// Ports:
//   i_nibble [3:0] : value to display
//   o_seg    [6:0] : {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module hex_to_seg7
   import cpu_display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/cpu_display_driver.sv
// ---------------------------------------------------------------------------
// cpu_display_driver
// Shows the CPU's 32-bit display register in hex on an 8-digit multiplexed,
// active-low seven-segment display. The register is copied into a shadow
// (unless frozen), digits are scanned with a CLK_DIV-cycle slot each, and the
// last cycle of every slot is blanked to avoid ghosting between digits.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous reset, active low
//   display_reg : value from the CPU, nibble i shown on digit i
//   freeze      : 1 = hold the shadow value and the change counter
//   seg  [6:0]  : {g,f,e,d,c,b,a}, active low
//   an   [7:0]  : digit enables, active low, one-hot-low
//   dp          : decimal point, active low, lit on digit 0 while frozen
//   change_cnt  : count of captured value changes, modulo 256
// Parameters:
//   CLK_DIV  : clock cycles per digit slot (>= 2)
//   BLANK_LZ : 1 = blank leading zero digits (digit 0 always shown)
// ---------------------------------------------------------------------------
module cpu_display_driver
   import cpu_display_pkg::*;
#(
   parameter int CLK_DIV  = 50000,
   parameter bit BLANK_LZ = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] display_reg,
   input  logic        freeze,
   output logic [6:0]  seg,
   output logic [7:0]  an,
   output logic        dp,
   output logic [7:0]  change_cnt
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] r_div;
   logic [2:0]       r_idx;
   logic [31:0]      r_shadow;
   logic [7:0]       r_change_cnt;
   logic [6:0]       r_seg;
   logic [7:0]       r_an;
   logic             r_dp;

   logic             w_tick;
   logic [3:0]       w_nibbles [NUM_DIGITS];
   logic             w_upper_zero [NUM_DIGITS];
   logic [6:0]       w_seg_dec;
   logic             w_digit_blank;

   assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

   // Per-digit nibble and "everything from this digit upward is zero" flag.
   // Digit 0 is never treated as a leading zero so a zero value still shows.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nibbles[gi] = r_shadow[4*gi +: 4];
      if (gi == 0) begin : g_first
         assign w_upper_zero[gi] = 1'b0;
      end else begin : g_upper
         assign w_upper_zero[gi] = (r_shadow[31:4*gi] == '0);
      end
   end

   hex_to_seg7 u_decode (
      .i_nibble (w_nibbles[r_idx]),
      .o_seg    (w_seg_dec)
   );

   assign w_digit_blank = BLANK_LZ && w_upper_zero[r_idx];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_shadow     <= '0;
         r_change_cnt <= '0;
         r_div        <= '0;
         r_idx        <= '0;
         r_an         <= AN_OFF;
         r_seg        <= SEG_BLANK;
         r_dp         <= 1'b1;
      end else begin
         // Capture: freeze sampled on the same edge as display_reg, so a
         // change arriving together with freeze is not taken.
         if (!freeze) begin
            r_shadow <= display_reg;
            if (display_reg != r_shadow) begin
               r_change_cnt <= r_change_cnt + 8'd1;
            end
         end

         // Slot divider and digit index.
         if (w_tick) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end

         // Output registers. The tick edge loads a blank slot; the digit
         // after it is driven from the advanced index on the next edge,
         // using whatever shadow value is current by then.
         if (w_tick) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
         end else begin
            r_an  <= ~(8'd1 << r_idx);
            r_seg <= w_digit_blank ? SEG_BLANK : w_seg_dec;
            r_dp  <= ~(freeze && (r_idx == 3'd0));
         end
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign dp         = r_dp;
   assign change_cnt = r_change_cnt;

endmodule

// File: tb/tb_cpu_display_driver.sv
// ---------------------------------------------------------------------------
// tb_cpu_display_driver
// Two instances with CLK_DIV=4 share all inputs: one shows every digit, the
// other blanks leading zeros. A reference model based on the elapsed cycle
// count since reset predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_cpu_display_driver;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic [31:0] display_reg = 32'h0;

   logic [6:0]  seg_full, seg_lz;
   logic [7:0]  an_full, an_lz;
   logic        dp_full, dp_lz;
   logic [7:0]  cnt_full, cnt_lz;

   cpu_display_driver #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b0)) dut_full (
      .clk         (clk),
      .rst         (rst),
      .display_reg (display_reg),
      .freeze      (freeze),
      .seg         (seg_full),
      .an          (an_full),
      .dp          (dp_full),
      .change_cnt  (cnt_full)
   );

   cpu_display_driver #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b1)) dut_lz (
      .clk         (clk),
      .rst         (rst),
      .display_reg (display_reg),
      .freeze      (freeze),
      .seg         (seg_lz),
      .an          (an_lz),
      .dp          (dp_lz),
      .change_cnt  (cnt_lz)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model state
   logic [31:0] m_shadow = 32'h0;
   logic [7:0]  m_cnt    = 8'h0;
   int          m_t      = 0;     // non-reset edges since the last reset

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at t=%0t: observed %h, expected %h", tag, $time, obs, exp);
      end
   endtask

   // One clock edge: predict, clock, update the model, compare.
   task automatic step();
      logic [7:0] e_an;
      logic [6:0] e_seg_full, e_seg_lz;
      logic       e_dp;
      logic [7:0] e_cnt;
      int         d;
      e_cnt = m_cnt;
      if (!rst) begin
         e_an = 8'hFF; e_seg_full = 7'h7F; e_seg_lz = 7'h7F; e_dp = 1'b1; e_cnt = 8'h0;
      end else begin
         if (!freeze && display_reg != m_shadow) e_cnt = m_cnt + 8'd1;
         if (m_t % CLK_DIV == CLK_DIV - 1) begin
            e_an = 8'hFF; e_seg_full = 7'h7F; e_seg_lz = 7'h7F; e_dp = 1'b1;
         end else begin
            d          = (m_t / CLK_DIV) % 8;
            e_an       = 8'hFF - (8'd1 << d);
            e_seg_full = hex_seg(4'((m_shadow / (32'd1 << (4 * d))) % 16));
            e_seg_lz   = (d != 0 && 64'(m_shadow) < (64'd1 << (4 * d))) ? 7'h7F : e_seg_full;
            e_dp       = (freeze && d == 0) ? 1'b0 : 1'b1;
         end
      end
      @(posedge clk);
      if (!rst) begin
         m_shadow = 32'h0; m_cnt = 8'h0; m_t = 0;
      end else begin
         if (!freeze) m_shadow = display_reg;
         m_cnt = e_cnt;
         m_t++;
      end
      #1;
      check("an",      32'(an_full),  32'(e_an));
      check("an_lz",   32'(an_lz),    32'(e_an));
      check("seg",     32'(seg_full), 32'(e_seg_full));
      check("seg_lz",  32'(seg_lz),   32'(e_seg_lz));
      check("dp",      32'(dp_full),  32'(e_dp));
      check("dp_lz",   32'(dp_lz),    32'(e_dp));
      check("cnt",     32'(cnt_full), 32'(e_cnt));
      check("cnt_lz",  32'(cnt_lz),   32'(e_cnt));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // Reset state, then first edge after release.
      rst = 1'b0; display_reg = 32'h0; freeze = 1'b0;
      run(3);
      check("reset_an", 32'(an_full), 32'hFF);
      check("reset_cnt", 32'(cnt_full), 32'h0);
      rst = 1'b1;
      step();
      check("first_an", 32'(an_full), 32'hFE);
      check("first_seg", 32'(seg_full), 32'h40);
      $display("reset phase: an=%h seg=%h cnt=%0d", an_full, seg_full, cnt_full);

      // Scan order over two full frames.
      display_reg = 32'h8765_4321;
      run(66);
      $display("scan phase: display_reg=%h cnt=%0d", display_reg, cnt_full);

      // Leading-zero blanking.
      display_reg = 32'h0000_00A0;
      run(64);
      display_reg = 32'h0;
      run(32);
      $display("blank phase: cnt=%0d", cnt_full);

      // Freeze: raised on the same edge as a value change.
      display_reg = 32'hFFFF_FFFF;
      run(32);
      freeze = 1'b1; display_reg = 32'h0;
      run(40);
      freeze = 1'b0;
      run(8);
      $display("freeze phase: cnt=%0d", cnt_full);

      // change_cnt wrap from a fresh reset.
      rst = 1'b0; display_reg = 32'h1;
      step();
      rst = 1'b1;
      for (int k = 0; k < 256; k++) begin
         display_reg = (k % 2 == 1) ? 32'h2 : 32'h1;
         step();
      end
      check("wrap_zero", 32'(cnt_full), 32'h0);
      display_reg = 32'h3;
      step();
      check("wrap_one", 32'(cnt_full), 32'h1);
      $display("wrap phase: cnt=%0d", cnt_full);

      // Reset in the middle of digit 5.
      begin : mid_reset
         int guard;
         guard = 0;
         while (!(((m_t / CLK_DIV) % 8 == 5) && (m_t % CLK_DIV == 1)) && guard < 100) begin
            step();
            guard++;
         end
         check("reach_digit5", 32'(guard < 100), 32'h1);
      end
      rst = 1'b0;
      step();
      check("midrst_an", 32'(an_full), 32'hFF);
      rst = 1'b1;
      step();
      check("restart_an", 32'(an_full), 32'hFE);
      run(8);
      $display("mid-scan reset phase: an=%h", an_full);

      // Randomized stimulus.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) != 0)
            display_reg = $urandom >> $urandom_range(0, 31);
         freeze = ($urandom_range(0, 7) == 0);
         rst    = ($urandom_range(0, 149) != 0);
         step();
      end
      rst = 1'b1; freeze = 1'b0;
      run(4);
      $display("random phase: cnt=%0d", cnt_full);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/cpu_display_driver.md
Name: cpu_display_driver

Overview:
- Consumes the CPU's 32-bit display_reg output and drives an 8-digit, multiplexed, active-low seven-segment display in hexadecimal.
- Sits at the board top level between RISCy_CPU and the display pins.
- Captures display_reg into a shadow register and scans the digits with a programmable refresh divider.
- Blanks one cycle between digits (anti-ghosting), optionally blanks leading zeros, and counts value changes for debug.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot; legal range is 2 or more.
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all 8 digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- display_reg  in  32  value from RISCy_CPU; nibble i is shown on digit i.
- freeze  in  1  1 = hold shadow value; ignore display_reg.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit enables, active-low, one-hot-low; an[i] selects digit i.
- dp  out  1  decimal point, active-low; lit on digit 0 only while freeze=1.
- change_cnt  out  8  number of captured value changes, modulo 256.

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - shadow=0, div=0, idx=0, change_cnt=0.
  - an=8'hFF, seg=7'h7F, dp=1.
  - Reset has priority over freeze and over every other event.
  - Reset asserted mid-scan aborts the scan immediately; there is no partial-state carryover.
- Capture:
  - Each cycle with freeze=0, shadow <= display_reg.
  - In the same cycle, if display_reg != shadow, then change_cnt <= change_cnt+1, wrapping 255->0.
  - With freeze=1, shadow and change_cnt hold.
- Divider:
  - div counts 0..CLK_DIV-1; tick = (div==CLK_DIV-1).
  - On tick: div wraps to 0 and idx advances, wrapping 7->0.
- Output stage: all outputs are registered.
  - In the cycle after a tick edge: an=8'hFF, seg=7'h7F, dp=1 (blank slot).
  - At all other edges:
    - an = ~(1<<idx).
    - seg = decode(shadow[4*idx+3:4*idx]), or 7'h7F if the digit is blanked.
    - dp = ~(freeze & idx==0).
  - Each digit is therefore shown for CLK_DIV-1 cycles plus 1 blank cycle.
  - The full frame is 8*CLK_DIV cycles.
- Leading-zero blanking (BLANK_LZ=1): digit i (i>=1) is blanked when shadow[31:4*i]==0.
  - Evaluation uses the current shadow, so blanking changes take effect with the value change.
- Latency: a change on display_reg reaches seg 2 edges later when that digit is selected (1 edge capture, 1 edge output register).
- After reset release:
  - The first edge drives an=8'hFE showing digit 0 of shadow=0.
  - seg=7'h40 after the capture pipeline, given display_reg nibble 0 = 0.
- Decode table, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous events:
  - A tick concurrent with a shadow change: the blank slot is emitted first, then the new idx shows the new shadow.
  - freeze rising in the same cycle as a display_reg change: the change is not captured.

Decomposition:
- Shared package cpu_display_pkg holds:
  - The 16-entry hex-to-segment constant table.
  - SEG_BLANK=7'h7F and AN_OFF=8'hFF.
  - NUM_DIGITS=8.
- One sub-module, hex_to_seg7: a combinational nibble-to-segment decoder used by the output stage.
- Divider, scan, capture and output registers stay in cpu_display_driver.

Test Plan:
- Reset state, CLK_DIV=4: hold rst=0 for 3 edges -> an=FF, seg=7F, dp=1, change_cnt=0. Release -> first edge an=FE.
- Scan order: display_reg=32'h8765_4321, BLANK_LZ=0, CLK_DIV=4.
  - Expected sequence per digit: FE seg=79, blank, FD seg=24, blank, FB seg=30, and so on up to 7F seg=00, then wrap to FE.
  - Check: 3 lit cycles plus 1 blank cycle per digit; frame = 32 cycles.
- Leading-zero blanking: display_reg=32'h0000_00A0, BLANK_LZ=1.
  - Digit 0 seg=40; digit 1 seg=08.
  - Digits 2..7 have their an low but seg=7F.
  - display_reg=0 -> only digit 0 shows 40.
- Freeze: display_reg=32'hFFFF_FFFF, then freeze=1, then display_reg=0.
  - All digits keep seg=0E.
  - dp=0 only while an=FE.
  - change_cnt unchanged during freeze.
- change_cnt wrap: toggle display_reg between 1 and 2 on every cycle for 256 cycles -> change_cnt returns to 0. One extra change -> 1.
- Reset mid-scan: assert rst=0 while idx=5 -> next edge an=FF and idx=0. After release, scan restarts at digit 0 with div=0.
